// File: rtl/full_adder.sv
// One-bit full adder with a registered capture stage and a bit-serial
// (LSB-first) adder that keeps its carry between clock cycles.
module full_adder #(
    parameter logic SER_CARRY_INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry,
    input  logic cap_en,
    output logic sum_q,
    output logic carry_q,
    output logic valid_q,
    input  logic ser_en,
    input  logic ser_clr,
    output logic ser_sum,
    output logic ser_c
);

    logic ser_carry_next;

    assign sum     = a ^ b ^ cin;
    assign carry   = (a & b) | (a & cin) | (b & cin);

    // The serial path adds a and b against its own stored carry; cin is not used here.
    assign ser_sum        = a ^ b ^ ser_c;
    assign ser_carry_next = (a & b) | (a & ser_c) | (b & ser_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= cap_en;
            if (cap_en) begin
                sum_q   <= sum;
                carry_q <= carry;
            end
        end
    end

    // A clear takes priority over an enabled serial step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_c <= SER_CARRY_INIT;
        end else if (ser_clr) begin
            ser_c <= SER_CARRY_INIT;
        end else if (ser_en) begin
            ser_c <= ser_carry_next;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder using an expected-value queue.
module tb_full_adder;

    localparam logic INIT = 1'b0;

    logic clk = 1'b0;
    logic rst_n, a, b, cin, cap_en, ser_en, ser_clr;
    logic sum, carry, sum_q, carry_q, valid_q, ser_sum, ser_c;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [3:0] exp_q[$];

    // Bench-side register model
    logic m_sq, m_cq, m_v, m_sc;

    full_adder #(.SER_CARRY_INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .sum(sum), .carry(carry), .cap_en(cap_en),
        .sum_q(sum_q), .carry_q(carry_q), .valid_q(valid_q),
        .ser_en(ser_en), .ser_clr(ser_clr), .ser_sum(ser_sum), .ser_c(ser_c)
    );

    always #5 clk = ~clk;

    function automatic logic maj(input logic x, input logic y, input logic z);
        logic [1:0] t;
        t = {1'b0, x} + {1'b0, y} + {1'b0, z};
        return t[1];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs);
        logic [3:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %b but scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp);
            end
        end
    endtask

    // Combinational view: {0, ser_sum, carry, sum}
    task automatic chk_comb(input string tag);
        logic [1:0] s;
        s = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        exp_q.push_back({1'b0, a ^ b ^ m_sc, s});
        chk(tag, {1'b0, ser_sum, carry, sum});
    endtask

    task automatic chk_regs(input string tag);
        exp_q.push_back({m_sq, m_cq, m_v, m_sc});
        chk(tag, {sum_q, carry_q, valid_q, ser_c});
    endtask

    // Advance the model from the current inputs, then sample 1 after the edge.
    task automatic step();
        logic [1:0] s;
        s = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        if (cap_en) begin
            m_sq = s[0];
            m_cq = s[1];
        end
        m_v = cap_en;
        if (ser_clr)     m_sc = INIT;
        else if (ser_en) m_sc = maj(a, b, m_sc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ser_a, ser_b, ser_exp;
        logic [2:0] v;
        rst_n = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        cap_en = 1'b0; ser_en = 1'b0; ser_clr = 1'b0;
        m_sq = 1'b0; m_cq = 1'b0; m_v = 1'b0; m_sc = INIT;

        #2;
        exp_q.push_back({3'b000, INIT});
        chk("reset_regs", {sum_q, carry_q, valid_q, ser_c});
        a = 1'b1; b = 1'b1; cin = 1'b0;
        #1;
        chk_comb("comb_in_reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive combinational truth table
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, cin} = v;
            #1;
            chk_comb($sformatf("comb_%03b", v));
        end

        // Capture, then hold with cap_en low
        @(negedge clk);
        a = 1'b1; b = 1'b0; cin = 1'b1; cap_en = 1'b1;
        step();
        exp_q.push_back({3'b011, INIT});
        chk("capture_101", {sum_q, carry_q, valid_q, ser_c});
        @(negedge clk);
        cap_en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        step();
        chk_regs("capture_hold");

        // Serial 0111 + 0011, cin toggled and capture running alongside
        ser_a = 4'b0111; ser_b = 4'b0011; ser_exp = 4'b1010;
        @(negedge clk);
        ser_clr = 1'b1;
        step();
        chk_regs("ser_clr");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ser_clr = 1'b0; ser_en = 1'b1;
            a = ser_a[i]; b = ser_b[i]; cin = ~cin; cap_en = (i == 2);
            #1;
            exp_q.push_back({3'b000, ser_exp[i]});
            chk($sformatf("ser_sum_bit%0d", i), {3'b000, ser_sum});
            chk_comb($sformatf("ser_comb_bit%0d", i));
            step();
            chk_regs($sformatf("ser_regs_bit%0d", i));
        end
        exp_q.push_back(4'b0000);
        chk("ser_final_carry", {3'b000, ser_c});

        // Clear wins over enable with a=b=1
        @(negedge clk);
        cap_en = 1'b0; ser_en = 1'b1; a = 1'b1; b = 1'b1;
        step();
        chk_regs("ser_carry_set");
        @(negedge clk);
        ser_clr = 1'b1;
        step();
        exp_q.push_back({3'b000, INIT});
        chk("clr_beats_en", {3'b000, ser_c});

        // Async reset between edges after a capture with serial carry set
        @(negedge clk);
        ser_clr = 1'b0; ser_en = 1'b1; cap_en = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        step();
        chk_regs("pre_reset");
        #2;
        rst_n = 1'b0;
        m_sq = 1'b0; m_cq = 1'b0; m_v = 1'b0; m_sc = INIT;
        #1;
        chk_regs("async_reset");
        chk_comb("comb_during_reset");
        @(posedge clk);
        #1;
        chk_regs("reset_held");
        @(negedge clk);
        rst_n = 1'b1; cap_en = 1'b0; ser_en = 1'b0;

        // Random combinational vectors
        for (int i = 0; i < 12; i++) begin
            v = 3'($urandom_range(0, 7));
            {a, b, cin} = v;
            #1;
            chk_comb($sformatf("rand%0d_%03b", i, v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
